// File: rtl/onehot_decoder_pipe_pkg.sv
// Package dec_pkg: shared types and helpers for the one-hot decoder pipeline.
// Holds the occupancy state type, the default code width and the
// code-width -> output-width helper used by both the top and the decoder.
package dec_pkg;

    // Default binary code width; output width is 2**DEF_SEL_W.
    localparam int DEF_SEL_W = 2;

    // Buffer occupancy: nothing held, main register only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    // One-hot output width for a given code width.
    function automatic int out_w(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/onehot_decoder_pipe_dec_comb.sv
// onehot_dec_comb: purely combinational binary code + enable -> one-hot.
// Bit k of the result is set only when the enable is high and the code
// equals k; with the enable low the whole word is zero.
module onehot_dec_comb
    import dec_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W,
    localparam int OUT_W = out_w(SEL_W)
) (
    input  logic [SEL_W-1:0] i_code,
    input  logic             i_en,
    output logic [OUT_W-1:0] o_onehot
);

    // One comparator per output line.
    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_line
            assign o_onehot[gi] = i_en && (i_code == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/onehot_decoder_pipe.sv
// onehot_decoder_pipe: registered binary-to-one-hot decoder on a
// valid/ready stream, with a 2-entry (main + skid) buffer so the input
// side sustains one beat per cycle while in_ready stays a register.
// Optional feature: define DEC_XFER_CNT_EN to add the xfer_cnt port, a
// saturating count of output handshakes.
module onehot_decoder_pipe
    import dec_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W,
    parameter int CNT_W = 16,
    localparam int OUT_W = out_w(SEL_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_code,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot
`ifdef DEC_XFER_CNT_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt
`endif
);

    occ_e             r_state;
    logic             r_in_ready;
    logic [OUT_W-1:0] r_main;
    logic [OUT_W-1:0] r_skid;

    logic [OUT_W-1:0] w_dec_onehot;
    logic             w_push;
    logic             w_pop;

    // Decode ahead of the register stage so the stored beat is already one-hot.
    onehot_dec_comb #(
        .SEL_W (SEL_W)
    ) u_dec (
        .i_code   (in_code),
        .i_en     (in_en),
        .o_onehot (w_dec_onehot)
    );

    assign w_push     = in_valid && r_in_ready;
    assign w_pop      = out_valid && out_ready;
    assign in_ready   = r_in_ready;
    assign out_valid  = (r_state != EMPTY);
    assign out_onehot = r_main;

    // Occupancy FSM with main/skid data registers; in_ready tracks the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_state <= ONE;
                        r_main  <= w_dec_onehot;
                    end
                end
                ONE: begin
                    if (w_push && !w_pop) begin
                        // Consumer stalled: park the new beat behind the main one.
                        r_state    <= TWO;
                        r_skid     <= w_dec_onehot;
                        r_in_ready <= 1'b0;
                    end else if (w_pop && !w_push) begin
                        r_state <= EMPTY;
                    end else if (w_push && w_pop) begin
                        r_main <= w_dec_onehot;
                    end
                end
                TWO: begin
                    // No push can happen here because in_ready is low.
                    if (w_pop) begin
                        r_state    <= ONE;
                        r_main     <= r_skid;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef DEC_XFER_CNT_EN
    logic [CNT_W-1:0] r_xfer_cnt;

    // Saturating count of output handshakes, including all-zero beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (w_pop && (r_xfer_cnt != {CNT_W{1'b1}})) begin
            r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`else
    // Counter absent; keep the width parameter referenced.
    logic [CNT_W-1:0] w_xfer_cnt_unused;
    assign w_xfer_cnt_unused = '0;
`endif

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Testbench for onehot_decoder_pipe (SEL_W=2, CNT_W=4).
// A queue-based reference model tracks the beats held by the decoder and
// is compared with the DUT on every falling edge; directed sections add
// literal expectations. Define DEC_XFER_CNT_EN to exercise the counter.
module tb_onehot_decoder_pipe;

    localparam int SEL_W = 2;
    localparam int CNT_W = 4;
    localparam int OUT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_code;
    logic             in_en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_onehot;
`ifdef DEC_XFER_CNT_EN
    logic [CNT_W-1:0] xfer_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [OUT_W-1:0] m_q[$];
    int               m_cnt = 0;
    bit               m_live = 0;

    onehot_decoder_pipe #(
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_en      (in_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot)
`ifdef DEC_XFER_CNT_EN
        ,
        .xfer_cnt   (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of at most two decoded words; handshakes derived from it.
    always @(posedge clk) begin
        bit push, pop;
        if (!rst_n) begin
            m_q.delete();
            m_cnt = 0;
        end else begin
            push = in_valid && (m_q.size() < 2);
            pop  = (m_q.size() > 0) && out_ready;
            if (pop) begin
                void'(m_q.pop_front());
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
            if (push) m_q.push_back(in_en ? OUT_W'(1 << in_code) : '0);
        end
        m_live = 1;
    end

    // Compare process: checks every cycle once the model has seen an edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("model_out_valid", 32'(out_valid), 32'(m_q.size() > 0));
            chk("model_in_ready", 32'(in_ready), 32'(m_q.size() < 2));
            if (m_q.size() > 0) chk("model_onehot", 32'(out_onehot), 32'(m_q[0]));
`ifdef DEC_XFER_CNT_EN
            chk("model_xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [OUT_W-1:0] exp_stream [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'd3;
        in_en     = 1'b1;
        out_ready = 1'b0;

        // 1. Reset with in_valid held high
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_onehot", 32'(out_onehot), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        chk("rst_release_valid", 32'(out_valid), 32'd0);
        $display("reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);

        // 2. Back-to-back streaming
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_code  = 2'(i);
            in_en    = 1'b1;
            tick();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_onehot", 32'(out_onehot), 32'(exp_stream[i]));
            $display("stream: code=%0d onehot=%b", i, out_onehot);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", 32'(out_valid), 32'd0);

        // 3. Enable low
        in_valid = 1'b1;
        in_code  = 2'd2;
        in_en    = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("en_low_valid", 32'(out_valid), 32'd1);
        chk("en_low_onehot", 32'(out_onehot), 32'h0);
        $display("en_low: code=2 onehot=%b", out_onehot);
        tick();

        // 4. Backpressure
        out_ready = 1'b0;
        in_en     = 1'b1;
        in_valid  = 1'b1;
        in_code   = 2'd3;
        tick();
        in_code = 2'd1;
        tick();
        in_valid = 1'b0;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold", 32'(out_onehot), 32'b1000);
        tick();
        chk("bp_stable", 32'(out_onehot), 32'b1000);
        out_ready = 1'b1;
        chk("bp_first", 32'(out_onehot), 32'b1000);
        tick();
        chk("bp_second", 32'(out_onehot), 32'b0010);
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);
        $display("backpressure: drained in order, out_valid=%0b", out_valid);

        // 5. Mid-operation reset while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'd0;
        tick();
        in_code = 2'd2;
        tick();
        in_valid = 1'b0;
        chk("mid_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_onehot", 32'(out_onehot), 32'h0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_stale", 32'(out_valid), 32'd0);
        end
        $display("mid_reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);

        // 6. Twenty transfers (counter saturates at 15 when present)
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_code  = 2'(i % 4);
            in_en    = (i % 5) != 0;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("final_empty", 32'(out_valid), 32'd0);
`ifdef DEC_XFER_CNT_EN
        chk("cnt_saturated", 32'(xfer_cnt), 32'd15);
        $display("counter: xfer_cnt=%0d", xfer_cnt);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
